// File: rtl/core_pkg.sv
// Shared definitions for the 64-bit 5-stage core.
// Contents:
//   XLEN, REG_AW      - datapath width and register-index width
//   alu_op2_e         - main-decoder ALUOp encoding handed to ALU control
//   ALU_* constants   - 4-bit ALU opcodes understood by the EX-stage ALU
package core_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    OP2_MEM    = 2'b00,
    OP2_BRANCH = 2'b01,
    OP2_RTYPE  = 2'b10,
    OP2_ITYPE  = 2'b11
  } alu_op2_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_BNE = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  // Routes the ALU to its default NOR path; legal, but marks an unsupported op.
  localparam logic [3:0] ALU_BAD = 4'b1111;

endpackage

// File: rtl/alu_ctrl.sv
// ALU control decoder (purely combinational).
// Ports:
//   op2_i       in  2  main-decoder ALUOp (mem / branch / R-type / I-type)
//   funct3_i    in  3  instruction funct3
//   funct7_5_i  in  1  instruction bit 30 (selects SUB for R-type funct3 000)
//   alu_op_o    out 4  ALU opcode
module alu_ctrl
  import core_pkg::*;
(
  input  logic [1:0] op2_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    unique case (alu_op2_e'(op2_i))
      OP2_MEM: alu_op_o = ALU_ADD;
      OP2_BRANCH: begin
        unique case (funct3_i)
          3'b000:  alu_op_o = ALU_SUB;   // beq: compare by subtraction
          3'b001:  alu_op_o = ALU_BNE;
          3'b100:  alu_op_o = ALU_SLT;   // blt
          default: alu_op_o = ALU_SUB;
        endcase
      end
      OP2_RTYPE, OP2_ITYPE: begin
        unique case (funct3_i)
          // Bit 30 of an I-type word is immediate bits, so only R-type may SUB.
          3'b000:  alu_op_o = (op2_i == OP2_RTYPE && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op_o = ALU_AND;
          3'b110:  alu_op_o = ALU_OR;
          3'b001:  alu_op_o = ALU_SLL;
          3'b010:  alu_op_o = ALU_SLT;
          default: alu_op_o = ALU_BAD;
        endcase
      end
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   id_*_i                         decoded fields of the instruction in ID
//   flush_i                        taken branch; the instruction entering EX is killed
//   exmem_*_i, memwb_*_i           destination/result of the two downstream stages
//   stall_o                        load-use hazard; upstream holds PC and IF/ID
//   alu_a_o, alu_b_o, alu_op_o     ALU operands and opcode
//   ex_store_data_o                forwarded rs2 for stores
//   ex_rd_o, ex_*_o                registered destination and control bits
// Handshake: none; stall_o is a combinational hold request to the upstream
// stages, asserted in the same cycle the hazard is visible, and this stage
// loads a bubble on that edge while ID keeps presenting the same instruction.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [1:0]        id_alu_op2_i,
  input  logic [2:0]        id_funct3_i,
  input  logic              id_funct7_5_i,
  input  logic              id_alu_src_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              id_branch_i,
  input  logic              flush_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]   exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]   memwb_result_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  output logic [3:0]        alu_op_o,
  output logic [XLEN-1:0]   ex_store_data_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_valid_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              ex_branch_o
);

  // Registered state
  logic              valid_q,      valid_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              branch_q,     branch_d;
  logic              alu_src_q,    alu_src_d;
  logic [REG_AW-1:0] rd_q,         rd_d;
  logic [REG_AW-1:0] rs1_q,        rs1_d;
  logic [REG_AW-1:0] rs2_q,        rs2_d;
  logic [XLEN-1:0]   rs1_data_q,   rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q,   rs2_data_d;
  logic [XLEN-1:0]   imm_q,        imm_d;
  logic [3:0]        alu_op_q,     alu_op_d;

  logic [3:0]        id_alu_op;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;
  logic [XLEN-1:0]   b_raw;

  alu_ctrl u_alu_ctrl (
    .op2_i      (id_alu_op2_i),
    .funct3_i   (id_funct3_i),
    .funct7_5_i (id_funct7_5_i),
    .alu_op_o   (id_alu_op)
  );

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    stall_o = valid_q && mem_read_q && (rd_q != '0) && id_valid_i &&
              ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));
  end

  // Next-state: flush or stall loads a bubble, otherwise capture ID.
  always_comb begin
    valid_d      = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    rd_d         = '0;
    rs1_d        = '0;
    rs2_d        = '0;
    rs1_data_d   = '0;
    rs2_data_d   = '0;
    imm_d        = '0;
    alu_op_d     = ALU_ADD;
    if (!flush_i && !stall_o) begin
      valid_d      = id_valid_i;
      mem_read_d   = id_mem_read_i;
      mem_write_d  = id_mem_write_i;
      reg_write_d  = id_reg_write_i;
      mem_to_reg_d = id_mem_to_reg_i;
      branch_d     = id_branch_i;
      alu_src_d    = id_alu_src_i;
      rd_d         = id_rd_i;
      rs1_d        = id_rs1_i;
      rs2_d        = id_rs2_i;
      rs1_data_d   = id_rs1_data_i;
      rs2_data_d   = id_rs2_data_i;
      imm_d        = id_imm_i;
      alu_op_d     = id_alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
      alu_src_q    <= 1'b0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      alu_op_q     <= ALU_ADD;
    end else begin
      valid_q      <= valid_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      branch_q     <= branch_d;
      alu_src_q    <= alu_src_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      alu_op_q     <= alu_op_d;
    end
  end

  // Forwarding: the younger EX/MEM result beats MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs1_q)) begin
      fwd_rs1 = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs1_q)) begin
      fwd_rs1 = memwb_result_i;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs2_q)) begin
      fwd_rs2 = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs2_q)) begin
      fwd_rs2 = memwb_result_i;
    end
  end

  // Shift amounts are bounded to 0..63 by keeping only the low six bits.
  always_comb begin
    b_raw   = alu_src_q ? imm_q : fwd_rs2;
    alu_b_o = b_raw;
    if (alu_op_q == ALU_SLL) begin
      alu_b_o = {{(XLEN-6){1'b0}}, b_raw[5:0]};
    end
  end

  assign alu_a_o         = fwd_rs1;
  assign alu_op_o        = alu_op_q;
  assign ex_store_data_o = fwd_rs2;
  assign ex_rd_o         = rd_q;
  assign ex_valid_o      = valid_q;
  assign ex_mem_read_o   = mem_read_q;
  assign ex_mem_write_o  = mem_write_q;
  assign ex_reg_write_o  = reg_write_q;
  assign ex_mem_to_reg_o = mem_to_reg_q;
  assign ex_branch_o     = branch_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vectors, a behavioural model
// of the EX-side instruction, a per-cycle compare process and literal checks.
module tb_id_ex_stage;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT inputs
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [XLEN-1:0]   id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [1:0]        id_alu_op2_i;
  logic [2:0]        id_funct3_i;
  logic              id_funct7_5_i, id_alu_src_i;
  logic              id_mem_read_i, id_mem_write_i, id_reg_write_i, id_mem_to_reg_i, id_branch_i;
  logic              flush_i;
  logic              exmem_reg_write_i, memwb_reg_write_i;
  logic [REG_AW-1:0] exmem_rd_i, memwb_rd_i;
  logic [XLEN-1:0]   exmem_result_i, memwb_result_i;

  // DUT outputs
  logic              stall_o;
  logic [XLEN-1:0]   alu_a_o, alu_b_o, ex_store_data_o;
  logic [3:0]        alu_op_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic              ex_valid_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o, ex_branch_o;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_alu_op2_i(id_alu_op2_i), .id_funct3_i(id_funct3_i), .id_funct7_5_i(id_funct7_5_i),
    .id_alu_src_i(id_alu_src_i), .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_to_reg_i(id_mem_to_reg_i), .id_branch_i(id_branch_i),
    .flush_i(flush_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
    .stall_o(stall_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_branch_o(ex_branch_o)
  );

  // Scoreboard counters
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the instruction currently sitting in EX
  typedef struct {
    bit              valid, mem_read, mem_write, reg_write, mem_to_reg, branch, alu_src;
    bit [REG_AW-1:0] rd, rs1, rs2;
    bit [XLEN-1:0]   d1, d2, imm;
    bit [3:0]        op;
  } ex_instr_t;

  ex_instr_t m;
  bit model_live = 0;

  // ALU opcode from the decode table, written as a lookup on mnemonic rules.
  function automatic bit [3:0] model_op(input bit [1:0] op2, input bit [2:0] f3, input bit f7);
    if (op2 == 2'd0) return 4'd2;
    if (op2 == 2'd1) begin
      if (f3 == 3'd1) return 4'd5;
      if (f3 == 3'd4) return 4'd10;
      return 4'd6;
    end
    if (f3 == 3'd0) return (op2 == 2'd2 && f7) ? 4'd6 : 4'd2;
    if (f3 == 3'd7) return 4'd0;
    if (f3 == 3'd6) return 4'd1;
    if (f3 == 3'd1) return 4'd7;
    if (f3 == 3'd2) return 4'd10;
    return 4'd15;
  endfunction

  function automatic bit model_stall();
    return m.valid && m.mem_read && m.rd != 0 && id_valid_i &&
           (m.rd == id_rs1_i || m.rd == id_rs2_i);
  endfunction

  function automatic bit [XLEN-1:0] model_fwd(input bit [REG_AW-1:0] rs, input bit [XLEN-1:0] rf);
    if (rs == 0) return rf;
    if (exmem_reg_write_i && exmem_rd_i == rs) return exmem_result_i;
    if (memwb_reg_write_i && memwb_rd_i == rs) return memwb_result_i;
    return rf;
  endfunction

  always @(posedge clk) begin
    bit st;
    st = model_stall();
    if (reset || flush_i || st) begin
      m = '{default: 0};
      m.op = 4'd2;
      if (reset) model_live = 1;
    end else begin
      m.valid = id_valid_i;         m.mem_read = id_mem_read_i;
      m.mem_write = id_mem_write_i; m.reg_write = id_reg_write_i;
      m.mem_to_reg = id_mem_to_reg_i; m.branch = id_branch_i;
      m.alu_src = id_alu_src_i;     m.rd = id_rd_i;
      m.rs1 = id_rs1_i;             m.rs2 = id_rs2_i;
      m.d1 = id_rs1_data_i;         m.d2 = id_rs2_data_i;
      m.imm = id_imm_i;
      m.op = model_op(id_alu_op2_i, id_funct3_i, id_funct7_5_i);
    end
  end

  // Compare process: every cycle once the model has seen reset.
  always @(negedge clk) begin
    bit [XLEN-1:0] a, s, b;
    if (model_live) begin
      a = model_fwd(m.rs1, m.d1);
      s = model_fwd(m.rs2, m.d2);
      b = m.alu_src ? m.imm : s;
      if (m.op == 4'd7) b = b % 64;
      chk("m_stall",      stall_o,         model_stall());
      chk("m_alu_a",      alu_a_o,         a);
      chk("m_alu_b",      alu_b_o,         b);
      chk("m_store",      ex_store_data_o, s);
      chk("m_alu_op",     alu_op_o,        m.op);
      chk("m_rd",         ex_rd_o,         m.rd);
      chk("m_valid",      ex_valid_o,      m.valid);
      chk("m_mem_read",   ex_mem_read_o,   m.mem_read);
      chk("m_mem_write",  ex_mem_write_o,  m.mem_write);
      chk("m_reg_write",  ex_reg_write_o,  m.reg_write);
      chk("m_mem_to_reg", ex_mem_to_reg_o, m.mem_to_reg);
      chk("m_branch",     ex_branch_o,     m.branch);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
    id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0;
    id_alu_op2_i = 0; id_funct3_i = 0; id_funct7_5_i = 0; id_alu_src_i = 0;
    id_mem_read_i = 0; id_mem_write_i = 0; id_reg_write_i = 0; id_mem_to_reg_i = 0; id_branch_i = 0;
  endtask

  task automatic fwd_idle();
    exmem_reg_write_i = 0; exmem_rd_i = 0; exmem_result_i = 0;
    memwb_reg_write_i = 0; memwb_rd_i = 0; memwb_result_i = 0;
  endtask

  // op2 / funct3 / f7_5 decode table with hand-computed opcodes
  logic [1:0] tv_op2 [8] = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
  logic [2:0] tv_f3  [8] = '{3'b000, 3'b100, 3'b011, 3'b111, 3'b110, 3'b010, 3'b010, 3'b101};
  logic       tv_f7  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] tv_exp [8] = '{4'b0010, 4'b1010, 4'b0110, 4'b0000, 4'b0001, 4'b1010, 4'b1010, 4'b0010};

  initial begin
    reset = 1; flush_i = 0;
    id_idle(); fwd_idle();
    tick(); tick();
    reset = 0;

    // Idle after reset
    at_sample();
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_op",    alu_op_o, 4'b0010);
    chk("rst_a",     alu_a_o, 0);
    chk("rst_b",     alu_b_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_rd",    ex_rd_o, 0);

    // R-type sub
    tick();
    id_valid_i = 1; id_rs1_i = 1; id_rs2_i = 2; id_rd_i = 3;
    id_rs1_data_i = 10; id_rs2_data_i = 3; id_alu_op2_i = 2'b10;
    id_funct3_i = 3'b000; id_funct7_5_i = 1; id_reg_write_i = 1;
    tick(); id_idle();
    at_sample();
    chk("sub_op", alu_op_o, 4'b0110);
    chk("sub_a",  alu_a_o, 10);
    chk("sub_b",  alu_b_o, 3);
    chk("sub_rw", ex_reg_write_o, 1);

    // Double forward: EX/MEM wins, then MEM/WB when EX/MEM targets x0
    tick();
    id_valid_i = 1; id_rs1_i = 5; id_rs2_i = 6; id_rd_i = 8;
    id_rs1_data_i = 64'h11; id_rs2_data_i = 64'h22; id_alu_op2_i = 2'b10; id_reg_write_i = 1;
    tick(); id_idle();
    exmem_reg_write_i = 1; exmem_rd_i = 5; exmem_result_i = 64'hAA;
    memwb_reg_write_i = 1; memwb_rd_i = 5; memwb_result_i = 64'hBB;
    at_sample();
    chk("fwd_exmem", alu_a_o, 64'hAA);
    chk("fwd_nob",   alu_b_o, 64'h22);
    exmem_rd_i = 0;
    #1;
    chk("fwd_memwb", alu_a_o, 64'hBB);
    tick(); fwd_idle();

    // Load-use: ld x7 in EX, add reading x7 in ID
    id_valid_i = 1; id_rs1_i = 1; id_rd_i = 7; id_alu_op2_i = 2'b00; id_alu_src_i = 1;
    id_imm_i = 8; id_mem_read_i = 1; id_reg_write_i = 1; id_mem_to_reg_i = 1;
    tick(); id_idle();
    id_valid_i = 1; id_rs1_i = 2; id_rs2_i = 7; id_rd_i = 9; id_rs1_data_i = 64'h20;
    id_alu_op2_i = 2'b10; id_reg_write_i = 1;
    at_sample();
    chk("lu_stall", stall_o, 1);
    tick();
    at_sample();
    chk("lu_bubble_valid", ex_valid_o, 0);
    chk("lu_stall_once",   stall_o, 0);
    tick(); id_idle();
    memwb_reg_write_i = 1; memwb_rd_i = 7; memwb_result_i = 64'h100;
    at_sample();
    chk("lu_add_valid", ex_valid_o, 1);
    chk("lu_add_a",     alu_a_o, 64'h20);
    chk("lu_add_b",     alu_b_o, 64'h100);
    tick(); fwd_idle();

    // Flush while stalling
    id_valid_i = 1; id_rs1_i = 3; id_rd_i = 4; id_alu_op2_i = 2'b00; id_alu_src_i = 1;
    id_mem_read_i = 1; id_reg_write_i = 1; id_mem_to_reg_i = 1;
    tick(); id_idle();
    id_valid_i = 1; id_rs1_i = 4; id_rs2_i = 1; id_rd_i = 6; id_alu_op2_i = 2'b10;
    id_reg_write_i = 1; id_branch_i = 1; flush_i = 1;
    at_sample();
    chk("fl_stall", stall_o, 1);
    tick(); flush_i = 0; id_idle();
    at_sample();
    chk("fl_valid",  ex_valid_o, 0);
    chk("fl_ctrl",   {ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o, ex_branch_o}, 0);
    chk("fl_rd",     ex_rd_o, 0);
    chk("fl_op",     alu_op_o, 4'b0010);

    // slli with imm 0x41: shift amount masked to 1
    tick();
    id_valid_i = 1; id_rs1_i = 1; id_rd_i = 2; id_rs1_data_i = 5; id_imm_i = 64'h41;
    id_alu_op2_i = 2'b11; id_funct3_i = 3'b001; id_alu_src_i = 1; id_reg_write_i = 1;
    tick(); id_idle();
    at_sample();
    chk("slli_op", alu_op_o, 4'b0111);
    chk("slli_b",  alu_b_o, 1);

    // bne
    tick();
    id_valid_i = 1; id_alu_op2_i = 2'b01; id_funct3_i = 3'b001; id_branch_i = 1;
    tick(); id_idle();
    at_sample();
    chk("bne_op", alu_op_o, 4'b0101);

    // R-type funct3 101 is unsupported
    tick();
    id_valid_i = 1; id_alu_op2_i = 2'b10; id_funct3_i = 3'b101;
    tick(); id_idle();
    at_sample();
    chk("bad_op", alu_op_o, 4'b1111);

    // Remaining decode table
    for (int i = 0; i < 8; i++) begin
      tick();
      id_valid_i = 1; id_alu_op2_i = tv_op2[i]; id_funct3_i = tv_f3[i]; id_funct7_5_i = tv_f7[i];
      tick(); id_idle();
      at_sample();
      chk($sformatf("dec_%0d", i), alu_op_o, tv_exp[i]);
    end

    // Reset during a stall
    tick();
    id_valid_i = 1; id_rd_i = 9; id_alu_op2_i = 2'b00; id_mem_read_i = 1; id_reg_write_i = 1;
    tick(); id_idle();
    id_valid_i = 1; id_rs1_i = 9; id_alu_op2_i = 2'b10;
    at_sample();
    chk("rs_stall_before", stall_o, 1);
    reset = 1;
    tick(); reset = 0;
    at_sample();
    chk("rs_stall_after", stall_o, 0);
    chk("rs_mem_read",    ex_mem_read_o, 0);
    tick(); id_idle();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage 64-bit core, directly upstream of the EX-stage ALU.
- Registers decoded ID fields and generates the 4-bit ALU opcode from the 2-bit main-decoder op plus funct3/funct7[5].
- Applies EX/MEM and MEM/WB operand forwarding and drives the ALU a/b/ALUOp inputs.
- Detects load-use hazards, stalling ID and inserting a bubble.

Parameters:
- XLEN, 64, datapath width
- REG_AW, 5, register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  register indices
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_alu_op2_i  in  2  main-decoder op: 00 mem, 01 branch, 10 R-type, 11 I-type ALU
- id_funct3_i  in  3  instruction funct3
- id_funct7_5_i  in  1  instruction bit 30
- id_alu_src_i  in  1  1 = operand b is the immediate
- id_mem_read_i, id_mem_write_i, id_reg_write_i, id_mem_to_reg_i, id_branch_i  in  1 each  control bits
- flush_i  in  1  taken branch; kill the instruction entering EX
- exmem_reg_write_i  in  1  EX/MEM writes a register
- exmem_rd_i  in  REG_AW  EX/MEM destination
- exmem_result_i  in  XLEN  EX/MEM result
- memwb_reg_write_i  in  1  MEM/WB writes a register
- memwb_rd_i  in  REG_AW  MEM/WB destination
- memwb_result_i  in  XLEN  MEM/WB writeback data
- stall_o  out  1  load-use hazard; hold PC and IF/ID
- alu_a_o, alu_b_o  out  XLEN  ALU operands
- alu_op_o  out  4  ALU opcode
- ex_store_data_o  out  XLEN  forwarded rs2 for stores
- ex_rd_o  out  REG_AW  destination index
- ex_valid_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o, ex_branch_o  out  1 each  registered control bits

Behaviour:
- All state updates on posedge clk; one-cycle latency from ID inputs to EX outputs.
- Reset: all registers cleared.
  - ex_valid_o and all control outputs = 0, ex_rd_o = 0.
  - Registered alu_op = ADD (0010); data registers = 0, so alu_a_o = alu_b_o = 0.
- Load priority, highest first:
  - reset
  - flush_i: load bubble
  - stall_o: load bubble
  - otherwise: capture the ID fields
- Bubble contents: valid = 0, every control bit = 0, rd = 0, rs1 = rs2 = 0, alu_op = ADD. Data fields are don't-care and are zeroed.
- stall_o is combinational and asserts when all of the following hold:
  - ex_valid_o = 1, ex_mem_read_o = 1, ex_rd_o != 0, id_valid_i = 1
  - ex_rd_o == id_rs1_i, or ex_rd_o == id_rs2_i
- stall_o lasts exactly one cycle per load-use pair, because the bubble clears ex_mem_read.
- ALU control is decoded in ID and registered:
  - op2 00: ADD 0010.
  - op2 01 (branch), by funct3:
    - 000 (beq): 0110
    - 001 (bne): 0101
    - 100 (blt): 1010
    - other: 0110
  - op2 10 (R-type), by funct3:
    - 000: ADD, or SUB 0110 when f7_5 = 1
    - 111: AND 0000
    - 110: OR 0001
    - 001: SLL 0111
    - 010: SLT 1010
    - other: 1111
  - op2 11 (I-type): same as op2 10 except funct3 000 is always ADD (f7_5 ignored).
  - 1111 selects the ALU default NOR path; it is legal but flags an unsupported op.
- Forwarding is combinational and applied per operand (rs1 and rs2):
  - If exmem_reg_write_i = 1, exmem_rd_i != 0 and exmem_rd_i == rs: use exmem_result_i.
  - Else if memwb_reg_write_i = 1, memwb_rd_i != 0 and memwb_rd_i == rs: use memwb_result_i.
  - Else: use the registered register-file data.
  - EX/MEM always wins when both stages match.
  - x0 is never forwarded.
- Operand outputs:
  - alu_a_o = forwarded rs1.
  - ex_store_data_o = forwarded rs2.
  - alu_b_o = id_imm (registered) if alu_src, else forwarded rs2.
  - When alu_op = SLL, alu_b_o is masked to bits [5:0] with the upper bits zero, which bounds the shift to 0..63.
- Simultaneous flush_i and stall_o: the bubble is loaded. stall_o still asserts to upstream for that cycle.
- Reset mid-stall: stall_o drops the cycle after reset because ex_mem_read_o clears.

Decomposition:
- Shared package core_pkg:
  - ALU opcode constants: ALU_AND = 0000, ALU_OR = 0001, ALU_ADD = 0010, ALU_BNE = 0101, ALU_SUB = 0110, ALU_SLL = 0111, ALU_SLT = 1010, ALU_BAD = 1111.
  - ALUOp2 encodings.
  - XLEN.
- One sub-module: alu_ctrl, the combinational decoder from op2/funct3/f7_5 to alu_op.
- Forwarding muxes and hazard detection stay inline.

Test Plan:
- Reset for 2 cycles, then idle -> ex_valid_o = 0, alu_op_o = 0010, alu_a_o = alu_b_o = 0, stall_o = 0.
- R-type sub: rs1_data = 10, rs2_data = 3, op2 = 10, f3 = 000, f7_5 = 1 -> next cycle alu_op_o = 0110, a = 10, b = 3, ex_reg_write_o = 1.
- Double forward: EX/MEM rd = 5, result = 0xAA, MEM/WB rd = 5, result = 0xBB, EX instruction rs1 = 5 -> alu_a_o = 0xAA. Repeat with EX/MEM rd = 0 -> alu_a_o = 0xBB.
- Load-use: EX holds ld with rd = 7, ID holds add with rs2 = 7 -> stall_o = 1 for one cycle and the next EX is a bubble (ex_valid_o = 0). The add enters the cycle after, forwarding MEM/WB data.
- Flush with stall: flush_i = 1 while stall_o = 1 -> bubble loaded, all ex control outputs = 0.
- slli with imm = 0x41 -> alu_op_o = 0111, alu_b_o = 1. bne with f3 = 001 -> alu_op_o = 0101. R-type f3 = 101 -> alu_op_o = 1111.
